// File: rtl/alap_pkg.sv
// Shared types and constants for the ALAP controller and its function units.
package alap_pkg;

   localparam int F1_F_W = 4;
   localparam int F2_F_W = 2;

   localparam logic [F1_F_W-1:0] F1_FN_A = 4'h0;
   localparam logic [F1_F_W-1:0] F1_FN_B = 4'h1;
   localparam logic [F2_F_W-1:0] F2_FN_A = 2'h0;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_STEP_A = 3'd2,
      ST_STEP_B = 3'd3,
      ST_DONE   = 3'd4
   } state_t;

   typedef struct packed {
      logic              busy;
      logic              done;
      logic              in0_oe;
      logic              in1_oe;
      logic              f1_oe;
      logic              f2_oe;
      logic              out_oe;
      logic              r2_sel;
      logic              r1_en;
      logic              r2_en;
      logic              r3_en;
      logic [F1_F_W-1:0] f1_f;
      logic [F2_F_W-1:0] f2_f;
   } ctrl_t;

endpackage

// File: rtl/alap_ctrl.sv
// Moore sequencer for alap_dp: load, N two-step F1/F2 iterations, then present
// the result until acknowledged. Sole owner of the datapath tristate enables.
module alap_ctrl
   import alap_pkg::*;
#(
   parameter int                ITER_W = 4,
   parameter logic [F1_F_W-1:0] F1_A   = F1_FN_A,
   parameter logic [F2_F_W-1:0] F2_A   = F2_FN_A,
   parameter logic [F1_F_W-1:0] F1_B   = F1_FN_B
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              ack,
   input  logic [ITER_W-1:0] iter,
   output logic              busy,
   output logic              done,
   output logic              in0_oe,
   output logic              in1_oe,
   output logic              f1_oe,
   output logic              f2_oe,
   output logic              out_oe,
   output logic              r2_sel,
   output logic              r1_en,
   output logic              r2_en,
   output logic              r3_en,
   output logic [F1_F_W-1:0] f1_f,
   output logic [F2_F_W-1:0] f2_f
);

   localparam logic [ITER_W-1:0] CNT_ONE = ITER_W'(1);

   state_t            r_state;
   logic [ITER_W-1:0] r_cnt;
   ctrl_t             r_ctrl;

   // Output decode of a state; registered together with the state itself so
   // the outputs are always the Moore decode of the current state.
   function automatic ctrl_t ctrl_of(input state_t s);
      ctrl_t c;
      c = '0;
      case (s)
         ST_LOAD: begin
            c.busy   = 1'b1;
            c.in0_oe = 1'b1;
            c.in1_oe = 1'b1;
            c.r1_en  = 1'b1;
            c.r2_en  = 1'b1;
            c.r3_en  = 1'b1;
         end
         ST_STEP_A: begin
            c.busy  = 1'b1;
            c.f1_oe = 1'b1;
            c.f1_f  = F1_A;
            c.r3_en = 1'b1;
            c.f2_oe = 1'b1;
            c.f2_f  = F2_A;
            c.r2_en = 1'b1;
         end
         ST_STEP_B: begin
            c.busy  = 1'b1;
            c.f1_oe = 1'b1;
            c.f1_f  = F1_B;
            c.r1_en = 1'b1;
         end
         ST_DONE: begin
            c.done   = 1'b1;
            c.out_oe = 1'b1;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

   // Sequencer state, iteration down-counter and registered control outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_ctrl  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_cnt   <= iter;
                  r_state <= ST_LOAD;
                  r_ctrl  <= ctrl_of(ST_LOAD);
               end
            end
            ST_LOAD: begin
               if (r_cnt == '0) begin
                  r_state <= ST_DONE;
                  r_ctrl  <= ctrl_of(ST_DONE);
               end else begin
                  r_state <= ST_STEP_A;
                  r_ctrl  <= ctrl_of(ST_STEP_A);
               end
            end
            ST_STEP_A: begin
               r_state <= ST_STEP_B;
               r_ctrl  <= ctrl_of(ST_STEP_B);
            end
            ST_STEP_B: begin
               // Guarded decrement: the counter saturates rather than wrapping.
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - CNT_ONE;
               end
               if (r_cnt <= CNT_ONE) begin
                  r_state <= ST_DONE;
                  r_ctrl  <= ctrl_of(ST_DONE);
               end else begin
                  r_state <= ST_STEP_A;
                  r_ctrl  <= ctrl_of(ST_STEP_A);
               end
            end
            ST_DONE: begin
               if (ack) begin
                  r_state <= ST_IDLE;
                  r_ctrl  <= ctrl_of(ST_IDLE);
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_cnt   <= '0;
               r_ctrl  <= '0;
            end
         endcase
      end
   end

   assign busy   = r_ctrl.busy;
   assign done   = r_ctrl.done;
   assign in0_oe = r_ctrl.in0_oe;
   assign in1_oe = r_ctrl.in1_oe;
   assign f1_oe  = r_ctrl.f1_oe;
   assign f2_oe  = r_ctrl.f2_oe;
   assign out_oe = r_ctrl.out_oe;
   assign r2_sel = r_ctrl.r2_sel;
   assign r1_en  = r_ctrl.r1_en;
   assign r2_en  = r_ctrl.r2_en;
   assign r3_en  = r_ctrl.r3_en;
   assign f1_f   = r_ctrl.f1_f;
   assign f2_f   = r_ctrl.f2_f;

endmodule

// File: tb/tb_alap_ctrl.sv
// Directed and randomized bench for alap_ctrl against a cycle-phase reference model.
module tb_alap_ctrl;
   localparam int ITER_W = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              start = 1'b0;
   logic              ack = 1'b0;
   logic [ITER_W-1:0] iter = '0;
   logic busy, done, in0_oe, in1_oe, f1_oe, f2_oe, out_oe, r2_sel, r1_en, r2_en, r3_en;
   logic [3:0] f1_f;
   logic [1:0] f2_f;

   int checks = 0;
   int failures = 0;

   typedef enum int {PH_IDLE, PH_LOAD, PH_A, PH_B, PH_DONE} phase_t;

   alap_ctrl #(.ITER_W(ITER_W)) dut (
      .clk(clk), .rst(rst), .start(start), .ack(ack), .iter(iter),
      .busy(busy), .done(done), .in0_oe(in0_oe), .in1_oe(in1_oe),
      .f1_oe(f1_oe), .f2_oe(f2_oe), .out_oe(out_oe), .r2_sel(r2_sel),
      .r1_en(r1_en), .r2_en(r2_en), .r3_en(r3_en), .f1_f(f1_f), .f2_f(f2_f)
   );

   always #5 clk = ~clk;

   // Required control word for each phase, straight from the output table:
   // {busy,done,in0,in1,f1oe,f2oe,outoe,r2sel,r1en,r2en,r3en,f1_f,f2_f}
   function automatic logic [16:0] exp_word(input phase_t p);
      case (p)
         PH_LOAD: return {1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b1,4'h0,2'h0};
         PH_A:    return {1'b1,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b1,1'b1,4'h0,2'h0};
         PH_B:    return {1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,4'h1,2'h0};
         PH_DONE: return {1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,4'h0,2'h0};
         default: return 17'h0;
      endcase
   endfunction

   function automatic logic [16:0] act_word();
      return {busy,done,in0_oe,in1_oe,f1_oe,f2_oe,out_oe,r2_sel,r1_en,r2_en,r3_en,f1_f,f2_f};
   endfunction

   task automatic check(input string tag, input phase_t p);
      logic [16:0] e;
      logic [16:0] a;
      e = exp_word(p);
      a = act_word();
      checks++;
      assert (a === e) else begin
         failures++;
         $error("FAIL %s: observed=%h expected=%h", tag, a, e);
      end
      checks++;
      assert (((in0_oe & f1_oe) | (in1_oe & f2_oe) | (busy & done)) === 1'b0) else begin
         failures++;
         $error("FAIL %s_excl: observed in0&f1=%b in1&f2=%b busy&done=%b expected all 0",
                tag, in0_oe & f1_oe, in1_oe & f2_oe, busy & done);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Full transaction: start with N, check every phase, hold DONE, then ack.
   task automatic run(input int n, input int hold, input bit noisy, input string tag);
      start = 1'b1;
      iter  = ITER_W'(n);
      tick();
      check({tag, "_load"}, PH_LOAD);
      for (int k = 2; k <= 2 * n + 1; k++) begin
         start = noisy ? 1'($urandom_range(1)) : 1'b0;
         iter  = noisy ? ITER_W'($urandom) : iter;
         tick();
         check({tag, "_step"}, (k % 2 == 0) ? PH_A : PH_B);
      end
      start = noisy ? 1'($urandom_range(1)) : 1'b0;
      tick();
      check({tag, "_done"}, PH_DONE);
      for (int h = 0; h < hold; h++) begin
         start = noisy ? 1'($urandom_range(1)) : 1'b0;
         tick();
         check({tag, "_hold"}, PH_DONE);
      end
      ack   = 1'b1;
      start = noisy ? 1'($urandom_range(1)) : 1'b0;
      tick();
      check({tag, "_ack"}, PH_IDLE);
      ack   = 1'b0;
      start = 1'b0;
      tick();
      check({tag, "_idle"}, PH_IDLE);
   endtask

   initial begin
      #2;
      check("reset", PH_IDLE);
      #10;
      rst = 1'b1;
      tick();
      check("idle", PH_IDLE);

      // Async reset in the middle of STEP_A.
      start = 1'b1;
      iter  = 4'd3;
      tick();
      start = 1'b0;
      check("pre_rst_load", PH_LOAD);
      tick();
      check("pre_rst_a", PH_A);
      #1 rst = 1'b0;
      #1;
      check("async_rst", PH_IDLE);
      @(negedge clk);
      rst = 1'b1;
      tick();
      check("post_rst_idle", PH_IDLE);
      run(3, 0, 1'b0, "rerun3");

      run(0, 0, 1'b0, "n0");
      run(3, 1, 1'b0, "n3");
      run(15, 5, 1'b0, "n15");

      // ack beats start in DONE; start is not remembered.
      start = 1'b1;
      iter  = 4'd1;
      tick();
      start = 1'b0;
      check("sa_load", PH_LOAD);
      tick(); check("sa_a", PH_A);
      tick(); check("sa_b", PH_B);
      tick(); check("sa_done", PH_DONE);
      start = 1'b1;
      ack   = 1'b1;
      tick();
      check("sa_ack_wins", PH_IDLE);
      start = 1'b0;
      ack   = 1'b0;
      tick();
      check("sa_no_load", PH_IDLE);
      run(2, 0, 1'b0, "second_start");

      for (int r = 0; r < 12; r++) begin
         run($urandom_range(15), $urandom_range(4), 1'b1, "rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/alap_ctrl.md
# alap_ctrl

Sequencing controller for the ALAP floating-point datapath `alap_dp`. It accepts a start/ack handshake and an iteration count, then drives every datapath control line cycle by cycle. The sequence is a load, then N two-step iterations of F1/F2 write-back, then result presentation on `out`. It is the only owner of the datapath's tristate enables and guarantees bus1/bus2 are never double-driven.

## Interface
- `ITER_W`, 4: width of iteration count.
- `F1_A`, 4'h0: F1 function code issued in STEP_A.
- `F2_A`, 2'h0: F2 function code issued in STEP_A.
- `F1_B`, 4'h1: F1 function code issued in STEP_B.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  reset, asynchronous, active-low: 0 resets, 1 runs.
- `start`  in  1  request; sampled only in IDLE.
- `ack`  in  1  result consumed; sampled only in DONE.
- `iter`  in  ITER_W  iteration count; captured with `start`.
- `busy`  out  1  high in LOAD, STEP_A, STEP_B.
- `done`  out  1  high in DONE.
- `in0_oe`, `in1_oe`, `f1_oe`, `f2_oe`, `out_oe`  out  1 each  datapath tristate enables.
- `r2_sel`  out  1  R2 input mux select (0 = bus2).
- `r1_en`, `r2_en`, `r3_en`  out  1 each  register enables.
- `f1_f`  out  4  F1 function code.
- `f2_f`  out  2  F2 function code.

## Operation
- States: IDLE, LOAD, STEP_A, STEP_B, DONE. The FSM is Moore: every output decodes from state only and never combinationally from an input.
- IDLE: all outputs 0. If `start`=1, latch `iter` into `cnt` and go to LOAD.
- LOAD: `in0_oe`, `in1_oe`, `r1_en`, `r3_en`, `r2_en` = 1; `r2_sel`=0. Effect: R1 and R3 take in0, R2 takes in1.
  - Next state is DONE if `cnt`=0, otherwise STEP_A.
- STEP_A: `f1_oe`=1, `f1_f`=F1_A, `r3_en`=1; `f2_oe`=1, `f2_f`=F2_A, `r2_sel`=0, `r2_en`=1.
  - Both units read the pre-edge register values.
  - Next state: STEP_B.
- STEP_B: `f1_oe`=1, `f1_f`=F1_B, `r1_en`=1; `cnt` decrements.
  - Next state is DONE if `cnt`=1 before the decrement, otherwise STEP_A.
- DONE: `out_oe`=1, `done`=1, held until `ack`=1, then IDLE.
- `f1_f`/`f2_f` are 0 whenever the matching `*_oe` is 0. `r2_sel` is always 0 in this revision; the port is reserved for later schedules.
- Bus exclusivity invariants hold in every state, including reset:
  - never `in0_oe`&`f1_oe`;
  - never `in1_oe`&`f2_oe`.
- `start` outside IDLE and `ack` outside DONE are ignored. `iter` changes after capture have no effect.
- Simultaneous `start`+`ack` in DONE: ack wins and the FSM goes to IDLE. Start is not remembered and must be held or re-asserted in IDLE.
- Reset mid-operation: state goes to IDLE, `cnt` to 0, and all outputs to 0 asynchronously, without waiting for a clock edge.

## Timing
- Reset values: every output 0, state IDLE, `cnt` 0.
- Cycle 0 is the edge at which `start` is sampled in IDLE.
  - Cycle 1: LOAD.
  - Cycles 2 to 2N+1: STEP_A/STEP_B pairs, for N=`iter`.
  - From cycle 2N+2: DONE.
- Minimum latency start→done: 2 cycles (N=0); maximum 2·(2^ITER_W−1)+2 = 32 cycles for the default ITER_W.
- `done` rises the cycle after the last STEP_B and falls the cycle after `ack` is sampled high. Earliest next LOAD is 2 cycles after the ack edge.
- `cnt` is ITER_W bits, unsigned, and never wraps: it is decremented only in STEP_B with `cnt`≥1.

## Structure
- Shared package `alap_pkg` holds:
  - the state enum (IDLE, LOAD, STEP_A, STEP_B, DONE);
  - `F1_F_W`=4 and `F2_F_W`=2;
  - named function-code constants, shared with F1_alap/F2_alap.
- No sub-module. The block is one FSM plus one down-counter.
- A thin top `alap_top` instantiates `alap_ctrl` beside `alap_dp`. It lives outside this block.

## Test plan
- Reset then idle: `rst`=0 mid-STEP_A with `iter`=3 → all outputs 0 immediately, before the next edge. After release, `start`=1 re-runs the full sequence.
- `iter`=0, `start` pulse → LOAD for exactly 1 cycle, then DONE at cycle 2 with `out_oe`=`done`=1. `ack`=1 → IDLE next cycle.
- `iter`=3 → cycles 2–7 alternate STEP_A/STEP_B:
  - `f1_f`=0/1 and `f2_f`=0/–;
  - `r3_en`,`r2_en` in A; `r1_en` in B;
  - DONE at cycle 8.
- `iter`=15 (max) → exactly 30 step cycles, then DONE at cycle 32. `cnt` never underflows.
- In DONE: hold `ack`=0 for 5 cycles, so `done`/`out_oe` stay high. Then drive `start`=1 with `ack`=1 → IDLE, no LOAD; a second `start` → LOAD.
- Assertion over all runs: `in0_oe`&`f1_oe`=0, `in1_oe`&`f2_oe`=0, and `busy`&`done`=0 every cycle. `start` during busy changes nothing.
